// File: rtl/alu_bitserial_seq.sv
// alu_bitserial_seq: drives an external 1-bit ALU slice one bit pair per cycle,
// LSB first. It chains the slice carry through a register and assembles the
// WIDTH-bit result together with the carry, zero and signed-overflow flags.
//
// Handshake: start is sampled on a rising edge only in IDLE or DONE. When it is
// accepted, opa/opb/op are latched on that edge. busy is high for exactly WIDTH
// cycles. After that, done pulses for one cycle and result/flags become valid.
// The result and flags hold until the next operation reaches DONE. start is
// ignored while busy is high.
module alu_bitserial_seq #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] opa,
    input  logic [WIDTH-1:0] opb,
    output logic             slice_a,
    output logic             slice_b,
    output logic             slice_cin,
    output logic [2:0]       slice_op,
    input  logic             slice_r,
    input  logic             slice_cout,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             carry_out,
    output logic             zero,
    output logic             overflow,
    output logic [1:0]       state_dbg
);

    localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_q;
    state_t           state_d;
    logic             load;
    logic             last_bit;
    logic             is_arith;

    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic [WIDTH-1:0] res_sh;
    logic [WIDTH-1:0] res_next;
    logic [2:0]       op_q;
    logic             carry_q;
    logic             cin_msb;
    logic [CW-1:0]    cnt_q;

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic: accept start in IDLE or DONE, and run for exactly WIDTH cycles
    always_comb begin
        state_d = state_q;
        load    = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    load    = 1'b1;
                    state_d = RUN;
                end
            end
            RUN: begin
                if (cnt_q == LAST_BIT) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                if (start) begin
                    load    = 1'b1;
                    state_d = RUN;
                end else begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign last_bit = (state_q == RUN) && (cnt_q == LAST_BIT);
    assign is_arith = (op_q == 3'b010) || (op_q == 3'b110);
    assign res_next = {slice_r, res_sh[WIDTH-1:1]};
    // The carry into the MSB is whatever the carry register holds on the final bit
    assign cin_msb  = carry_q;

    // Operand shifters, carry chain, bit counter and the registered result/flags
    always_ff @(posedge clk) begin
        if (reset) begin
            a_sh      <= '0;
            b_sh      <= '0;
            res_sh    <= '0;
            op_q      <= 3'b000;
            carry_q   <= 1'b0;
            cnt_q     <= '0;
            result    <= '0;
            carry_out <= 1'b0;
            zero      <= 1'b0;
            overflow  <= 1'b0;
        end else if (load) begin
            a_sh    <= opa;
            b_sh    <= opb;
            res_sh  <= '0;
            op_q    <= op;
            // op[2] selects the inverted-b forms; for SUB the preset carry is the +1
            carry_q <= op[2];
            cnt_q   <= '0;
        end else if (state_q == RUN) begin
            a_sh    <= a_sh >> 1;
            b_sh    <= b_sh >> 1;
            res_sh  <= res_next;
            carry_q <= slice_cout;
            cnt_q   <= cnt_q + 1'b1;
            if (last_bit) begin
                result    <= res_next;
                carry_out <= slice_cout;
                zero      <= (res_next == '0);
                overflow  <= is_arith ? (cin_msb ^ slice_cout) : 1'b0;
            end
        end
    end

    // Status and slice drive; the slice sees zeros outside RUN
    always_comb begin
        busy      = (state_q == RUN);
        done      = (state_q == DONE);
        state_dbg = state_q;
        slice_a   = 1'b0;
        slice_b   = 1'b0;
        slice_cin = 1'b0;
        slice_op  = 3'b000;
        if (state_q == RUN) begin
            slice_a   = a_sh[0];
            slice_b   = b_sh[0];
            slice_cin = carry_q;
            slice_op  = op_q;
        end
    end

endmodule

// File: tb/tb_alu_bitserial_seq.sv
// Bench for alu_bitserial_seq: a 32-bit and an 8-bit instance, each wrapped
// around a behavioural 1-bit slice, checked against a word-level reference.
module tb_alu_bitserial_seq;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        go = 1'b0;
  logic        sel8 = 1'b0;
  logic [63:0] opa = '0;
  logic [63:0] opb = '0;
  logic [2:0]  op = '0;

  int n_checks = 0;
  int n_errors = 0;

  // clock/reset block
  always #5 clk = ~clk;

  // 32-bit instance
  logic        start32, sa32, sb32, sc32, sr32, sco32, busy32, done32, cy32, z32, ov32;
  logic [2:0]  sop32;
  logic [31:0] res32;
  logic [1:0]  st32;
  // 8-bit instance
  logic        start8, sa8, sb8, sc8, sr8, sco8, busy8, done8, cy8, z8, ov8;
  logic [2:0]  sop8;
  logic [7:0]  res8;
  logic [1:0]  st8;

  assign start32 = go & ~sel8;
  assign start8  = go & sel8;

  alu_bitserial_seq #(.WIDTH(32)) u32 (
    .clk(clk), .reset(reset), .start(start32), .op(op), .opa(opa[31:0]), .opb(opb[31:0]),
    .slice_a(sa32), .slice_b(sb32), .slice_cin(sc32), .slice_op(sop32),
    .slice_r(sr32), .slice_cout(sco32), .busy(busy32), .done(done32), .result(res32),
    .carry_out(cy32), .zero(z32), .overflow(ov32), .state_dbg(st32)
  );

  alu_bitserial_seq #(.WIDTH(8)) u8 (
    .clk(clk), .reset(reset), .start(start8), .op(op), .opa(opa[7:0]), .opb(opb[7:0]),
    .slice_a(sa8), .slice_b(sb8), .slice_cin(sc8), .slice_op(sop8),
    .slice_r(sr8), .slice_cout(sco8), .busy(busy8), .done(done8), .result(res8),
    .carry_out(cy8), .zero(z8), .overflow(ov8), .state_dbg(st8)
  );

  // Behavioural 1-bit slice: b optionally inverted by op[2], op[1:0] picks AND/OR/SUM/XOR
  function automatic logic [1:0] slice_fn(input logic a, input logic b, input logic c,
                                          input logic [2:0] o);
    logic bb, r, co;
    bb = b ^ o[2];
    case (o[1:0])
      2'b00:   r = a & bb;
      2'b01:   r = a | bb;
      2'b10:   r = a ^ bb ^ c;
      default: r = a ^ bb;
    endcase
    co = (a & bb) | (a & c) | (bb & c);
    return {co, r};
  endfunction

  always_comb {sco32, sr32} = slice_fn(sa32, sb32, sc32, sop32);
  always_comb {sco8, sr8}   = slice_fn(sa8, sb8, sc8, sop8);

  // Views of whichever instance is under test
  logic        busy_m, done_m, cy_m, z_m, ov_m;
  logic [63:0] res_m;
  logic [1:0]  st_m;
  assign busy_m = sel8 ? busy8 : busy32;
  assign done_m = sel8 ? done8 : done32;
  assign cy_m   = sel8 ? cy8 : cy32;
  assign z_m    = sel8 ? z8 : z32;
  assign ov_m   = sel8 ? ov8 : ov32;
  assign res_m  = sel8 ? {56'b0, res8} : {32'b0, res32};
  assign st_m   = sel8 ? st8 : st32;

  // Word-level reference: returns {overflow, carry_out, result}
  function automatic logic [65:0] ref_alu(input int w, input logic [63:0] a_in,
                                          input logic [63:0] b_in, input logic [2:0] o);
    logic [63:0] mask, a, bb, r;
    logic [64:0] sum;
    logic        ovf;
    mask = (w == 64) ? '1 : ((64'd1 << w) - 64'd1);
    a    = a_in & mask;
    bb   = (o[2] ? ~b_in : b_in) & mask;
    sum  = {1'b0, a} + {1'b0, bb} + {64'b0, o[2]};
    case (o[1:0])
      2'b00:   r = a & bb;
      2'b01:   r = a | bb;
      2'b10:   r = sum[63:0] & mask;
      default: r = a ^ bb;
    endcase
    ovf = ((o == 3'b010) || (o == 3'b110)) && (a[w-1] == bb[w-1]) && (sum[w-1] != a[w-1]);
    return {ovf, sum[w], r};
  endfunction

  // scoreboard: expected results queued at launch, popped at done
  logic [65:0] exp_q[$];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // driver: present operands with start for one edge (called at a negedge)
  task automatic launch(input logic [63:0] a, input logic [63:0] b, input logic [2:0] o);
    opa = a;
    opb = b;
    op  = o;
    exp_q.push_back(ref_alu(sel8 ? 8 : 32, a, b, o));
    go = 1'b1;
    @(negedge clk);
    go = 1'b0;
  endtask

  // Wait for done while scrambling inputs; optionally pulse start at RUN sample poke_at
  task automatic finish_op(input int poke_at);
    int lat = 0;
    int busy_n = 0;
    int w;
    logic [65:0] e;
    w = sel8 ? 8 : 32;
    while (!done_m && lat < 100) begin
      if (busy_m) busy_n++;
      go  = (lat == poke_at);
      opa = {$urandom, $urandom};
      opb = {$urandom, $urandom};
      op  = 3'($urandom_range(0, 7));
      @(negedge clk);
      lat++;
    end
    go = 1'b0;
    e = (exp_q.size() > 0) ? exp_q.pop_front() : '0;
    check("latency", 64'(lat), 64'(w));
    check("busy_cycles", 64'(busy_n), 64'(w));
    check("done", {63'b0, done_m}, 64'd1);
    check("result", res_m, e[63:0]);
    check("carry_out", {63'b0, cy_m}, {63'b0, e[64]});
    check("zero", {63'b0, z_m}, {63'b0, (e[63:0] == 64'd0)});
    check("overflow", {63'b0, ov_m}, {63'b0, e[65]});
  endtask

  // Full operation followed by the IDLE cycle: done must drop and result must hold
  task automatic do_op(input logic [63:0] a, input logic [63:0] b, input logic [2:0] o,
                       input int poke_at);
    logic [63:0] held;
    launch(a, b, o);
    finish_op(poke_at);
    held = res_m;
    @(negedge clk);
    check("done_pulse", {63'b0, done_m}, 64'd0);
    check("result_hold", res_m, held);
  endtask

  logic [2:0] ops_tab[8];
  int dones;

  initial begin
    ops_tab = '{3'b000, 3'b001, 3'b010, 3'b011, 3'b110, 3'b100, 3'b101, 3'b111};
    repeat (3) @(negedge clk);
    reset = 1'b0;

    // reset state, both instances
    check("rst_busy32", {63'b0, busy32}, 64'd0);
    check("rst_done32", {63'b0, done32}, 64'd0);
    check("rst_res32", {32'b0, res32}, 64'd0);
    check("rst_flags32", {61'b0, cy32, z32, ov32}, 64'd0);
    check("rst_res8", {56'b0, res8}, 64'd0);
    check("rst_flags8", {60'b0, busy8, cy8, z8, ov8}, 64'd0);
    check("rst_slice32", {58'b0, sa32, sb32, sc32, sop32}, 64'd0);

    // directed 32-bit cases
    sel8 = 1'b0;
    do_op(64'h7FFF_FFFF, 64'h1, 3'b010, -1);
    check("add_ovf_const", res_m, 64'h8000_0000);
    do_op(64'h5, 64'h5, 3'b110, -1);
    do_op(64'h3, 64'h5, 3'b110, -1);
    check("sub_neg_const", res_m, 64'hFFFF_FFFE);
    do_op(64'hF0F0_F0F0, 64'hFF00_FF00, 3'b000, -1);
    check("and_const", res_m, 64'hF000_F000);
    do_op(64'hF0F0_F0F0, 64'hFF00_FF00, 3'b001, -1);
    do_op(64'hAAAA_AAAA, 64'h5555_5555, 3'b011, -1);

    // start pulsed in RUN cycle 10 is ignored; then watch for a stray done
    do_op(64'h1234_5678, 64'h0FED_CBA9, 3'b010, 9);
    dones = 0;
    repeat (40) begin
      if (done_m) dones++;
      @(negedge clk);
    end
    check("no_extra_done", 64'(dones), 64'd0);

    // back-to-back: start held high through DONE, second op starts without IDLE
    opa = 64'h1111_1111; opb = 64'h2222_2222; op = 3'b010;
    exp_q.push_back(ref_alu(32, opa, opb, op));
    go = 1'b1;
    @(negedge clk);
    while (!done32 && busy32) begin
      go = 1'b1;
      @(negedge clk);
    end
    go = 1'b0;
    if (exp_q.size() > 0) void'(exp_q.pop_front());
    check("b2b_first_done", {63'b0, done32}, 64'd1);
    check("b2b_first_res", res_m, 64'h3333_3333);
    launch(64'h9, 64'hC, 3'b110);
    check("b2b_no_idle", {63'b0, busy_m}, 64'd1);
    finish_op(-1);
    @(negedge clk);

    // reset in RUN cycle 16 aborts the operation
    launch(64'h0F0F_0F0F, 64'h0101_0101, 3'b010);
    repeat (15) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    if (exp_q.size() > 0) void'(exp_q.pop_front());
    check("abort_state", {62'b0, st_m}, 64'd0);
    check("abort_busy", {63'b0, busy_m}, 64'd0);
    check("abort_result", res_m, 64'd0);
    check("abort_flags", {61'b0, cy_m, z_m, ov_m}, 64'd0);
    dones = 0;
    repeat (40) begin
      if (done_m) dones++;
      @(negedge clk);
    end
    check("abort_no_done", 64'(dones), 64'd0);
    do_op(64'h2, 64'h2, 3'b010, -1);
    check("add_after_reset", res_m, 64'h4);

    // random 32-bit
    for (int i = 0; i < 20; i++)
      do_op({$urandom, $urandom}, {$urandom, $urandom}, ops_tab[$urandom_range(0, 7)], -1);

    // 8-bit instance: boundaries then random
    sel8 = 1'b1;
    do_op(64'hFF, 64'h01, 3'b010, -1);
    check("w8_wrap_const", {62'b0, cy_m, z_m}, 64'h3);
    do_op(64'h80, 64'h80, 3'b010, -1);
    check("w8_ovf_const", {62'b0, cy_m, ov_m}, 64'h3);
    for (int i = 0; i < 20; i++)
      do_op({$urandom, $urandom}, {$urandom, $urandom}, ops_tab[$urandom_range(0, 7)], -1);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
